// File: rtl/hamming_decoder_stream.sv
// Streaming Hamming(7,4) decoder: syndrome, optional single-bit correction, and a saturating count of erroneous words.
// Latency: 1 cycle from the input transfer to out_valid carrying that word's result. Throughput is 1 word per cycle.
// Backpressure: in_ready = !out_valid || out_ready (combinational). The payload holds while out_valid && !out_ready.
//
// Ports: clk/rst_n (async active-low), in_valid/in_ready/in_code (7-bit codeword),
//        out_valid/out_ready/out_data/out_err/out_syndrome, err_cnt (CNT_W bits), cnt_clr.
// Build option: HAMMING_DEC_CORRECT_EN. When defined, a single-bit error is corrected. When undefined,
//        the decoder only detects errors and out_data comes from the raw codeword.
// Codeword layout: bit0=p1 bit1=p2 bit2=d0 bit3=p4 bit4=d1 bit5=d2 bit6=d3.

module hamming_decoder_stream #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic             out_err,
    output logic [2:0]       out_syndrome,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             cnt_clr
);

    logic             out_valid_q, out_valid_d;
    logic [3:0]       out_data_q, out_data_d;
    logic             out_err_q, out_err_d;
    logic [2:0]       out_syndrome_q, out_syndrome_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [2:0]       syn;
    logic [6:0]       flip;
    logic [6:0]       fixed_code;
    logic             in_xfer;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    assign in_ready = !out_valid_q || out_ready;
    assign in_xfer  = in_valid && in_ready;

    always_comb begin
        syn[0] = in_code[0] ^ in_code[2] ^ in_code[4] ^ in_code[6];
        syn[1] = in_code[1] ^ in_code[2] ^ in_code[5] ^ in_code[6];
        syn[2] = in_code[3] ^ in_code[4] ^ in_code[5] ^ in_code[6];

        // The syndrome value is the 1-based position of the flipped bit, and zero means no error.
        flip = '0;
        for (int i = 0; i < 7; i++) begin
            flip[i] = (syn == 3'(i + 1));
        end

`ifdef HAMMING_DEC_CORRECT_EN
        fixed_code = in_code ^ flip;
`else
        fixed_code = in_code;
`endif
    end

    always_comb begin
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        out_err_d      = out_err_q;
        out_syndrome_d = out_syndrome_q;
        err_cnt_d      = err_cnt_q;

        // A new word overrides the drain, so a simultaneous in/out transfer keeps out_valid high.
        if (in_xfer) begin
            out_valid_d    = 1'b1;
            out_data_d     = {fixed_code[6], fixed_code[5], fixed_code[4], fixed_code[2]};
            out_err_d      = (syn != 3'd0);
            out_syndrome_d = syn;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // A clear wins over a count in the same cycle, so that word is not counted.
        if (cnt_clr) begin
            err_cnt_d = '0;
        end else if (in_xfer && (syn != 3'd0) && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_err_q      <= 1'b0;
            out_syndrome_q <= '0;
            err_cnt_q      <= '0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_err_q      <= out_err_d;
            out_syndrome_q <= out_syndrome_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_err      = out_err_q;
    assign out_syndrome = out_syndrome_q;
    assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_hamming_decoder_stream.sv
// Bench for hamming_decoder_stream. Instance a uses CNT_W=8 and instance b uses CNT_W=2 to exercise saturation.
// A scoreboard derives every expected result from the position-XOR property of Hamming codes.
// Directed steps also pin hand-computed literal values.

module tb_hamming_decoder_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [6:0] in_code;
    logic       out_ready;
    logic       cnt_clr;

    logic       in_ready_a, out_valid_a, out_err_a;
    logic [3:0] out_data_a;
    logic [2:0] out_syndrome_a;
    logic [7:0] err_cnt_a;

    logic       in_ready_b, out_valid_b, out_err_b;
    logic [3:0] out_data_b;
    logic [2:0] out_syndrome_b;
    logic [1:0] err_cnt_b;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    always #5 clk = ~clk;

    hamming_decoder_stream #(.CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_code(in_code),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .out_err(out_err_a), .out_syndrome(out_syndrome_a),
        .err_cnt(err_cnt_a), .cnt_clr(cnt_clr)
    );

    hamming_decoder_stream #(.CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_code(in_code),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_err(out_err_b), .out_syndrome(out_syndrome_b),
        .err_cnt(err_cnt_b), .cnt_clr(cnt_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        assert_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // The syndrome is the XOR of the 1-based positions of all set bits.
    function automatic logic [2:0] pos_xor(input logic [6:0] code);
        logic [2:0] s = 3'd0;
        for (int i = 0; i < 7; i++) if (code[i]) s ^= 3'(i + 1);
        return s;
    endfunction

    // Expected payload {data[3:0], err, syndrome[2:0]} for one received codeword.
    function automatic logic [7:0] expect_of(input logic [6:0] code);
        logic [2:0] s = pos_xor(code);
        logic [6:0] c = code;
`ifdef HAMMING_DEC_CORRECT_EN
        if (s != 3'd0) c[s - 3'd1] = ~c[s - 3'd1];
`endif
        return {c[6], c[5], c[4], c[2], (s != 3'd0), s};
    endfunction

    // Encoder: place the data bits, then set the parity bits that cancel their position XOR.
    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [6:0] c = 7'd0;
        logic [2:0] s;
        c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
        s = pos_xor(c);
        c[0] = s[0]; c[1] = s[1]; c[3] = s[2];
        return c;
    endfunction

    // Scoreboard. Inputs change at posedge+1, so values seen at negedge are the ones the next posedge uses.
    logic [7:0] sb_q[$];
    int  exp_cnt_a = 0;
    int  exp_cnt_b = 0;
    bit  prev_in_xfer = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            exp_cnt_a = 0;
            exp_cnt_b = 0;
            prev_in_xfer = 0;
        end else begin
            check("sb_err_cnt_a", 32'(err_cnt_a), 32'(exp_cnt_a));
            check("sb_err_cnt_b", 32'(err_cnt_b), 32'(exp_cnt_b));
            check("sb_in_ready_a", 32'(in_ready_a), 32'(!out_valid_a || out_ready));
            check("sb_in_ready_b", 32'(in_ready_b), 32'(in_ready_a));
            check("sb_out_valid_b", 32'(out_valid_b), 32'(out_valid_a));
            if (prev_in_xfer) check("sb_latency", 32'(out_valid_a), 32'd1);
            if (out_valid_a) begin
                if (sb_q.size() == 0) begin
                    check("sb_spurious_out", 32'd1, 32'd0);
                end else begin
                    check("sb_payload_a", 32'({out_data_a, out_err_a, out_syndrome_a}), 32'(sb_q[0]));
                    check("sb_payload_b", 32'({out_data_b, out_err_b, out_syndrome_b}), 32'(sb_q[0]));
                    if (out_ready) void'(sb_q.pop_front());
                end
            end else begin
                check("sb_lost_word", 32'(sb_q.size()), 32'd0);
            end
            prev_in_xfer = in_valid && in_ready_a;
            if (prev_in_xfer) sb_q.push_back(expect_of(in_code));
            if (cnt_clr) begin
                exp_cnt_a = 0;
                exp_cnt_b = 0;
            end else if (prev_in_xfer && pos_xor(in_code) != 3'd0) begin
                if (exp_cnt_a < 255) exp_cnt_a++;
                if (exp_cnt_b < 3) exp_cnt_b++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_45_data;
    int flips;
    int pos;
    logic [6:0] cw;
    logic [6:0] err_codes[2];

    initial begin
`ifdef HAMMING_DEC_CORRECT_EN
        exp_45_data = 4'b1011;
`else
        exp_45_data = 4'b1001;
`endif
        err_codes[0] = 7'h45;
        err_codes[1] = 7'h01;

        // Reset, then idle.
        rst_n = 1'b0; in_valid = 1'b0; in_code = 7'h00; out_ready = 1'b1; cnt_clr = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        check("reset_out_valid", 32'(out_valid_a), 32'd0);
        check("reset_in_ready", 32'(in_ready_a), 32'd1);
        check("reset_payload", 32'({out_data_a, out_err_a, out_syndrome_a}), 32'd0);
        check("reset_err_cnt", 32'(err_cnt_a), 32'd0);

        // Check the encoder model against a hand-computed codeword.
        check("model_encode_b", 32'(encode(4'b1011)), 32'h55);

        // Clean word.
        in_valid = 1'b1; in_code = 7'h55;
        step();
        in_valid = 1'b0;
        check("clean_valid", 32'(out_valid_a), 32'd1);
        check("clean_data", 32'(out_data_a), 32'hB);
        check("clean_err", 32'(out_err_a), 32'd0);
        check("clean_syn", 32'(out_syndrome_a), 32'd0);
        check("clean_cnt", 32'(err_cnt_a), 32'd0);

        // Single-bit error in d1 (bit 4).
        in_valid = 1'b1; in_code = 7'h45;
        step();
        in_valid = 1'b0;
        check("err_syn", 32'(out_syndrome_a), 32'd5);
        check("err_flag", 32'(out_err_a), 32'd1);
        check("err_data", 32'(out_data_a), 32'(exp_45_data));
        check("err_cnt1", 32'(err_cnt_a), 32'd1);
        step();

        // Backpressure: the first word latches, and the second stalls until out_ready rises.
        out_ready = 1'b0; in_valid = 1'b1; in_code = 7'h01;
        step();
        in_code = 7'h55;
        check("bp_syn", 32'(out_syndrome_a), 32'd1);
        check("bp_data", 32'(out_data_a), 32'd0);
        check("bp_in_ready", 32'(in_ready_a), 32'd0);
        step(); step(); step();
        check("bp_hold_syn", 32'(out_syndrome_a), 32'd1);
        check("bp_hold_valid", 32'(out_valid_a), 32'd1);
        check("bp_cnt", 32'(err_cnt_a), 32'd2);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("bp_second_data", 32'(out_data_a), 32'hB);
        check("bp_second_syn", 32'(out_syndrome_a), 32'd0);
        check("bp_second_valid", 32'(out_valid_a), 32'd1);
        step();
        check("bp_drained", 32'(out_valid_a), 32'd0);

        // Full throughput: 16 back-to-back words, each with zero or one flipped bit.
        flips = 0;
        for (int d = 0; d < 16; d++) begin
            cw = encode(4'(d));
            pos = $urandom_range(0, 7);
            if (pos < 7) begin
                cw[pos] = ~cw[pos];
                flips++;
            end
            in_valid = 1'b1; in_code = cw;
            step();
        end
        in_valid = 1'b0;
        step(); step();
        check("tp_cnt_a", 32'(err_cnt_a), 32'(2 + flips));
        check("tp_cnt_b", 32'(err_cnt_b), 32'd3);

        // A clear with a simultaneous erroneous transfer leaves the counter at zero.
        cnt_clr = 1'b1; in_valid = 1'b1; in_code = 7'h45;
        step();
        cnt_clr = 1'b0; in_valid = 1'b0;
        check("clr_cnt_a", 32'(err_cnt_a), 32'd0);
        check("clr_cnt_b", 32'(err_cnt_b), 32'd0);

        // Counter saturation at 2^CNT_W-1.
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_code = err_codes[k % 2];
            step();
        end
        in_valid = 1'b0;
        step();
        check("sat_cnt_a", 32'(err_cnt_a), 32'd5);
        check("sat_cnt_b", 32'(err_cnt_b), 32'd3);
        cnt_clr = 1'b1; in_valid = 1'b1; in_code = 7'h01;
        step();
        cnt_clr = 1'b0; in_valid = 1'b0;
        check("sat_clr_a", 32'(err_cnt_a), 32'd0);
        check("sat_clr_b", 32'(err_cnt_b), 32'd0);
        step();

        // A reset in mid-stream drops the held word.
        out_ready = 1'b0; in_valid = 1'b1; in_code = 7'h55;
        step();
        in_valid = 1'b0;
        check("mid_valid", 32'(out_valid_a), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid_a), 32'd0);
        check("mid_rst_payload", 32'({out_data_a, out_err_a, out_syndrome_a}), 32'd0);
        step();
        rst_n = 1'b1; out_ready = 1'b1;
        step();
        check("post_rst_valid", 32'(out_valid_a), 32'd0);
        check("post_rst_ready", 32'(in_ready_a), 32'd1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/hamming_decoder_stream.md
Name: hamming_decoder_stream

Overview:
- Streaming Hamming(7,4) decoder with a registered output and valid/ready handshakes on both sides.
- Takes 7-bit codewords from the link and computes the 3-bit syndrome.
- Corrects any single-bit error, returns the 4 data bits, and keeps a saturating count of corrected words.
- Sits at the receive end of the link fed by the team's Hamming(7,4) encoder; its codeword bit layout is identical to that encoder's.

Parameters:
- CNT_W, 8, width of the saturating corrected-error counter (min 1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  codeword on in_code is valid.
- in_ready  output  1  decoder can accept a codeword this cycle.
- in_code  input  7  received codeword.
- out_valid  output  1  out_data/out_err/out_syndrome are valid.
- out_ready  input  1  downstream accepts the output this cycle.
- out_data  output  4  decoded (corrected) data bits.
- out_err  output  1  nonzero syndrome was seen for this word.
- out_syndrome  output  3  syndrome {s4,s2,s1} for this word.
- err_cnt  output  CNT_W  saturating count of accepted words with nonzero syndrome.
- cnt_clr  input  1  synchronous clear of err_cnt.

Behaviour:
- Codeword layout, index = bit of in_code:
  - 0 = p1, covers d0,d1,d3.
  - 1 = p2, covers d0,d2,d3.
  - 2 = d0.
  - 3 = p4, covers d1,d2,d3.
  - 4 = d1.
  - 5 = d2.
  - 6 = d3.
- Syndrome bits:
  - s1 = c0^c2^c4^c6
  - s2 = c1^c2^c5^c6
  - s4 = c3^c4^c5^c6
- Syndrome value S = {s4,s2,s1}. S != 0 means the bit at index S-1 is in error.
- Correction: corrected code = in_code XOR (one-hot at index S-1) when S != 0; out_data = {c6,c5,c4,c2} of the corrected code.
- Handshake:
  - Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
  - in_ready = !out_valid || out_ready. This is combinational, so there is no bubble and throughput is 1 word/cycle.
- Latency: exactly 1 cycle, from input transfer edge to out_valid high with that word's results.
- Output register:
  - On input transfer, load out_data, out_err, out_syndrome and set out_valid = 1.
  - Else on output transfer, clear out_valid.
  - Else hold.
  - Payload is held stable while out_valid && !out_ready.
- Simultaneous input and output transfer in the same cycle: the new word replaces the old one and out_valid stays 1.
- in_code is ignored when in_valid = 0 or in_ready = 0.
- err_cnt update priority:
  - cnt_clr has priority: err_cnt = 0 next cycle, even if an erroneous word is accepted the same cycle (that word is not counted).
  - Otherwise err_cnt increments by 1 on each input transfer with S != 0.
  - err_cnt saturates at 2^CNT_W-1 and never wraps.
- Double-bit errors are miscorrected, as inherent to (7,4). No detection is required.
- Reset (async assert, sync release is the integrator's responsibility):
  - out_valid = 0, out_data = 0, out_err = 0, out_syndrome = 0, err_cnt = 0.
  - in_ready = 1 after reset.
  - Reset mid-stream drops the held word with no output transfer.

Optional Feature:
- Macro HAMMING_DEC_CORRECT_EN.
- Defined: single-bit correction as above.
- Undefined: detect-only mode.
  - out_data = {c6,c5,c4,c2} of the raw, uncorrected in_code.
  - out_err and out_syndrome are still computed.
  - err_cnt counts S != 0 words identically.
- Handshake and latency are the same in both modes.

Test Plan:
- Reset, then idle: rst_n = 0 then 1 with in_valid = 0 -> out_valid = 0, in_ready = 1, err_cnt = 0, all outputs 0.
- Clean word: in_code = 7'h55 (data 4'b1011) with out_ready = 1 -> next cycle out_valid = 1, out_data = 4'b1011, out_err = 0, out_syndrome = 3'd0, err_cnt unchanged.
- Single-bit error: in_code = 7'h45 (bit 4 flipped) -> out_syndrome = 3'd5, out_err = 1, out_data = 4'b1011 (with CORRECT_EN), err_cnt += 1. Undefined macro -> out_data = 4'b1001.
- Backpressure: hold out_ready = 0, present 7'h01 then 7'h55 -> first word latched, out_syndrome = 1, out_data = 0. in_ready = 0 and the second word is stalled; payload is stable. Raise out_ready -> 7'h55's result follows the next cycle with no loss or duplication.
- Full throughput: out_ready = 1, 16 back-to-back words covering all data values, each with 0 or 1 random bit flip -> one output per cycle in order, correct data, err_cnt = number of flipped words.
- Counter saturation/clear: CNT_W = 2, send 5 erroneous words -> err_cnt = 3. Assert cnt_clr together with an erroneous transfer -> err_cnt = 0.
